// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - Shared MIPS control encodings: ALU ops, opcode/funct constants, FSM states.
package mips_pkg;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_XOR   = 4'b0011,
        ALU_ORI   = 4'b0100,
        ALU_ADDIU = 4'b0101,
        ALU_SUB   = 4'b0110,
        ALU_SLT   = 4'b0111,
        ALU_SLL   = 4'b1000,
        ALU_LUI   = 4'b1111
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    // Which rule the ALU-control decoder applies in the current state.
    typedef enum logic [1:0] {
        CLS_ADD   = 2'd0,
        CLS_SUB   = 2'd1,
        CLS_RTYPE = 2'd2,
        CLS_ITYPE = 2'd3
    } alu_cls_e;

    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            FN_SLL, FN_ADD, FN_ADDU, FN_SUB,
            FN_AND, FN_OR, FN_XOR, FN_SLT: funct_legal = 1'b1;
            default:                       funct_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - Combinational {state class, opcode, funct} -> alu_ctrl, ext_zero.
module alu_ctrl_dec
    import mips_pkg::*;
(
    input  alu_cls_e    cls,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [3:0]  alu_ctrl,
    output logic        ext_zero
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        ext_zero = 1'b0;
        case (cls)
            CLS_SUB: alu_ctrl = ALU_SUB;
            CLS_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: alu_ctrl = ALU_ADD;
                    FN_SUB:          alu_ctrl = ALU_SUB;
                    FN_AND:          alu_ctrl = ALU_AND;
                    FN_OR:           alu_ctrl = ALU_OR;
                    FN_XOR:          alu_ctrl = ALU_XOR;
                    FN_SLT:          alu_ctrl = ALU_SLT;
                    FN_SLL:          alu_ctrl = ALU_SLL;
                    default:         alu_ctrl = ALU_ADD;
                endcase
            end
            CLS_ITYPE: begin
                case (opcode)
                    OP_ADDIU: alu_ctrl = ALU_ADDIU;
                    OP_ORI: begin
                        alu_ctrl = ALU_ORI;
                        ext_zero = 1'b1;
                    end
                    OP_LUI: begin
                        alu_ctrl = ALU_LUI;
                        ext_zero = 1'b1;
                    end
                    default:  alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - Multi-cycle MIPS main control FSM; MC_CTRL_BNE_EN adds bne (opcode 0x05).
module mc_control_fsm
    import mips_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_write,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_en,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               ext_zero,
    output logic [3:0]         alu_ctrl,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               illegal_op,
    output logic [STATE_W-1:0] dbg_state
);

    state_e   state, state_next;
    alu_cls_e cls;
    logic     mem_req_s, mem_write_s, ir_write_s, pc_en_s, reg_write_s, illegal_s;
    logic     br_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_next;
    end

`ifdef MC_CTRL_BNE_EN
    assign br_taken = (opcode == OP_BNE) ? ~zero : zero;
`else
    assign br_taken = zero;
`endif

    always_comb begin
        state_next  = state;
        mem_req_s   = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        pc_en_s     = 1'b0;
        reg_write_s = 1'b0;
        illegal_s   = 1'b0;
        iord        = 1'b0;
        pc_src      = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        cls         = CLS_ADD;
        case (state)
            S_FETCH: begin
                mem_req_s  = 1'b1;
                alu_src_b  = 2'b01;
                ir_write_s = mem_ready;
                pc_en_s    = mem_ready;
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_RTYPE: begin
                        if (funct_legal(funct)) state_next = S_R_EXEC;
                        else begin
                            illegal_s  = 1'b1;
                            state_next = S_FETCH;
                        end
                    end
                    OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: state_next = S_I_EXEC;
                    OP_BEQ: state_next = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE: state_next = S_BRANCH;
`endif
                    OP_J:   state_next = S_JUMP;
                    default: begin
                        illegal_s  = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req_s = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write_s = 1'b1;
                mem_to_reg  = 1'b1;
                state_next  = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req_s   = 1'b1;
                mem_write_s = 1'b1;
                iord        = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a  = 1'b1;
                cls        = CLS_RTYPE;
                state_next = S_R_WB;
            end
            S_R_WB: begin
                cls         = CLS_RTYPE;
                reg_write_s = 1'b1;
                reg_dst     = 1'b1;
                state_next  = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                cls        = CLS_ITYPE;
                state_next = S_I_WB;
            end
            S_I_WB: begin
                cls         = CLS_ITYPE;
                reg_write_s = 1'b1;
                state_next  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                cls        = CLS_SUB;
                pc_src     = 2'b01;
                pc_en_s    = br_taken;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_en_s    = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    alu_ctrl_dec u_alu_ctrl_dec (
        .cls      (cls),
        .opcode   (opcode),
        .funct    (funct),
        .alu_ctrl (alu_ctrl),
        .ext_zero (ext_zero)
    );

    // Strobes are killed while reset is asserted so an abandoned access cannot complete.
    assign mem_req    = mem_req_s   & rst_n;
    assign mem_write  = mem_write_s & rst_n;
    assign ir_write   = ir_write_s  & rst_n;
    assign pc_en      = pc_en_s     & rst_n;
    assign reg_write  = reg_write_s & rst_n;
    assign illegal_op = illegal_s   & rst_n;
    assign dbg_state  = STATE_W'(state);

endmodule
